pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Parametrised hazard, forwarding and stall controller for the in-order MIPS pipeline. It keeps its own shadow scoreboard of in-flight destination registers per post-ID stage, so stages do not need to feed back write addresses. From that scoreboard it generates per-operand forward selects, load-use stalls, a store-data bypass, taken-branch squash and memory-busy freezes. It also keeps saturating stall counters for performance debug.

Parameters:
REG_AW, 5, register address width
NUM_FWD, 3, tracked producer stages after ID (1=EXE, 2=MEM, 3=WB)
LOAD_READY_STAGE, 2, first stage index where load data is forwardable
CNT_W, 16, width of each stall counter
SEL_W, 2, forward select width; must satisfy 2**SEL_W > NUM_FWD

Ports:
clk  in  1  main clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_rs / id_rt  in  REG_AW  ID source register addresses
id_rs_used / id_rt_used  in  1  operand is actually read
id_is_store  in  1  ID instruction is a store (rt is store data)
id_is_load  in  1  ID instruction is a load
id_wen / id_waddr  in  1 / REG_AW  ID instruction writes the register file at id_waddr
id_branch_taken  in  1  branch/jump resolved taken in ID
mem_busy  in  1  data memory not ready; MEM cannot retire this cycle
fwd_a_sel / fwd_b_sel  out  SEL_W  0 = register file, k = stage k result
fwd_store  out  1  store data taken from MEM-stage load result
if_en / id_en / exe_en / mem_en / wb_en  out  1  stage enables
id_flush  out  1  load a bubble into ID next edge
exe_flush  out  1  load a bubble into EXE next edge
load_stall_cnt / mem_stall_cnt  out  CNT_W  saturating stall-cycle counters

Behaviour:
- Scoreboard: NUM_FWD records {valid, waddr, is_load}; record 1 = EXE ... record NUM_FWD = WB.
- On each non-frozen edge, records shift one stage toward WB; the oldest record is dropped.
- Record 1 is loaded from the ID inputs (valid = id_valid & id_wen & id_waddr != 0), or cleared when exe_flush is high.
- Forward select: for each used operand, sel = smallest k with a valid record k whose waddr matches; otherwise 0. Address 0 never matches.
- Load-use: a matching record k that is a load with k < LOAD_READY_STAGE raises load_stall.
- Store exception: when all of the following hold, no stall is raised, fwd_store = 1 and fwd_b_sel = 0:
  - the only blocking match is on rt;
  - id_is_store = 1;
  - k = LOAD_READY_STAGE-1.
- Priority (combinational):
  - mem_busy: all enables 0, no flush, records hold.
  - Else load_stall: if_en = id_en = 0, exe_flush = 1, id_branch_taken ignored.
  - Else id_branch_taken: id_flush = 1, all enables 1.
  - Else: all enables 1, no flush.
- Counters increment by 1 per cycle in their stall condition, saturate at all-ones and never wrap. A cycle with mem_busy counts only in mem_stall_cnt.
- Latency: selects and stalls are combinational from current ID inputs and records. Records update on the same edge the stage registers do.
- Reset (rst_n low, asynchronous):
  - records invalid, counters 0;
  - all enables 0, id_flush = exe_flush = 1, fwd_*_sel = 0, fwd_store = 0.
  - Deassertion takes effect at the first clk edge after rst_n rises. Reset mid-stall abandons the stall cleanly.

Optional Feature:
Macro HAZARD_DEBUG_STEP_EN.
- When defined: adds input ports debug_en and debug_step and a registered copy of debug_step.
  - While debug_en = 1, every enable is forced to 0 and records hold, except in a cycle where debug_step rose (prev 0, now 1). That cycle behaves normally, giving one pipeline advance per step.
  - Counters do not count frozen debug cycles.
- When undefined: those ports do not exist and there is no extra logic.

Test Plan:
1. Record 1 = add writing r3; ID add reading rs = r3 -> fwd_a_sel = 1, no stall. Next cycle, ID reading r3 -> fwd_a_sel = 2.
2. Record 1 = lw r5; ID add rs = r5 -> exactly one cycle with if_en = id_en = 0, exe_flush = 1, load_stall_cnt +1. Following cycle: fwd_a_sel = 2, no stall.
3. Record 1 = lw r5; ID sw rt = r5, rs = r2 -> no stall, fwd_store = 1, fwd_b_sel = 0.
4. mem_busy held high 4 cycles concurrent with a load-use hazard -> all enables 0 for 4 cycles, mem_stall_cnt +4, load_stall_cnt unchanged. Load stall then resolves as in test 2.
5. id_branch_taken with no hazard -> id_flush = 1 for one cycle. Same branch during a load stall -> id_flush = 0 until the stall clears.
6. Drop rst_n mid-sequence asynchronously -> outputs reach their reset values before the next clk edge. Force load_stall_cnt to all-ones and stall again -> counter stays at all-ones.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// ============================================================================
// Module      : pipe_hazard_ctrl_if
// Description : ID-stage hazard request and control-response bundle.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_rs_used;
  logic              id_rt_used;
  logic              id_is_store;
  logic              id_is_load;
  logic              id_wen;
  logic [REG_AW-1:0] id_waddr;
  logic              id_branch_taken;
  logic              mem_busy;

  logic [SEL_W-1:0]  fwd_a_sel;
  logic [SEL_W-1:0]  fwd_b_sel;
  logic              fwd_store;
  logic              if_en;
  logic              id_en;
  logic              exe_en;
  logic              mem_en;
  logic              wb_en;
  logic              id_flush;
  logic              exe_flush;
  logic [CNT_W-1:0]  load_stall_cnt;
  logic [CNT_W-1:0]  mem_stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_is_store,
           id_is_load, id_wen, id_waddr, id_branch_taken, mem_busy,
    input  fwd_a_sel, fwd_b_sel, fwd_store, if_en, id_en, exe_en, mem_en,
           wb_en, id_flush, exe_flush, load_stall_cnt, mem_stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_is_store,
           id_is_load, id_wen, id_waddr, id_branch_taken, mem_busy,
    output fwd_a_sel, fwd_b_sel, fwd_store, if_en, id_en, exe_en, mem_en,
           wb_en, id_flush, exe_flush, load_stall_cnt, mem_stall_cnt
  );
endinterface

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Shadow-scoreboard forwarding/stall/flush controller with
//               saturating stall counters. Optional single-step debug freeze
//               is enabled by defining HAZARD_DEBUG_STEP_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
  parameter int REG_AW           = 5,
  parameter int NUM_FWD          = 3,
  parameter int LOAD_READY_STAGE = 2,
  parameter int CNT_W            = 16,
  parameter int SEL_W            = 2
) (
  input  logic clk,
  input  logic rst_n,
`ifdef HAZARD_DEBUG_STEP_EN
  input  logic debug_en,
  input  logic debug_step,
`endif
  pipe_hazard_ctrl_if.slave bus
);

  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] wa;
    logic              ld;
  } rec_t;

  rec_t             r_rec [1:NUM_FWD];
  logic             r_run;
  logic [CNT_W-1:0] r_load_cnt;
  logic [CNT_W-1:0] r_mem_cnt;

  logic             w_a_hit, w_a_ld, w_b_hit, w_b_ld;
  logic [SEL_W-1:0] w_a_k, w_b_k;
  logic             w_a_block, w_b_block, w_store_ok, w_load_stall;
  logic             w_dbg_hold, w_freeze, w_cnt_ok;

`ifdef HAZARD_DEBUG_STEP_EN
  logic r_dbg_step_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_dbg_step_q <= 1'b0;
    else        r_dbg_step_q <= debug_step;
  end

  // A rising debug_step lets exactly one cycle through the freeze.
  assign w_dbg_hold = debug_en & ~(debug_step & ~r_dbg_step_q);
`else
  assign w_dbg_hold = 1'b0;
`endif

  // Descending scan so the youngest matching producer wins.
  always_comb begin
    w_a_hit = 1'b0;
    w_a_ld  = 1'b0;
    w_a_k   = '0;
    w_b_hit = 1'b0;
    w_b_ld  = 1'b0;
    w_b_k   = '0;
    for (int k = NUM_FWD; k >= 1; k--) begin
      if (bus.id_rs_used && (bus.id_rs != '0) && r_rec[k].vld &&
          (r_rec[k].wa == bus.id_rs)) begin
        w_a_hit = 1'b1;
        w_a_ld  = r_rec[k].ld;
        w_a_k   = SEL_W'(k);
      end
      if (bus.id_rt_used && (bus.id_rt != '0) && r_rec[k].vld &&
          (r_rec[k].wa == bus.id_rt)) begin
        w_b_hit = 1'b1;
        w_b_ld  = r_rec[k].ld;
        w_b_k   = SEL_W'(k);
      end
    end
  end

  assign w_a_block    = w_a_hit & w_a_ld & (int'(w_a_k) < LOAD_READY_STAGE);
  assign w_b_block    = w_b_hit & w_b_ld & (int'(w_b_k) < LOAD_READY_STAGE);
  assign w_store_ok   = bus.id_is_store & w_b_block & ~w_a_block &
                        (int'(w_b_k) == LOAD_READY_STAGE - 1);
  assign w_load_stall = (w_a_block | w_b_block) & ~w_store_ok;

  assign w_freeze = ~r_run | w_dbg_hold | bus.mem_busy;
  assign w_cnt_ok = r_run & ~w_dbg_hold;

  always_comb begin
    bus.if_en     = 1'b0;
    bus.id_en     = 1'b0;
    bus.exe_en    = 1'b0;
    bus.mem_en    = 1'b0;
    bus.wb_en     = 1'b0;
    bus.id_flush  = 1'b0;
    bus.exe_flush = 1'b0;
    bus.fwd_a_sel = w_a_k;
    bus.fwd_b_sel = w_store_ok ? '0 : w_b_k;
    bus.fwd_store = w_store_ok;
    if (!r_run) begin
      bus.id_flush  = 1'b1;
      bus.exe_flush = 1'b1;
      bus.fwd_a_sel = '0;
      bus.fwd_b_sel = '0;
      bus.fwd_store = 1'b0;
    end else if (w_dbg_hold || bus.mem_busy) begin
      bus.if_en = 1'b0;
    end else if (w_load_stall) begin
      bus.exe_en    = 1'b1;
      bus.mem_en    = 1'b1;
      bus.wb_en     = 1'b1;
      bus.exe_flush = 1'b1;
    end else begin
      bus.if_en    = 1'b1;
      bus.id_en    = 1'b1;
      bus.exe_en   = 1'b1;
      bus.mem_en   = 1'b1;
      bus.wb_en    = 1'b1;
      bus.id_flush = bus.id_branch_taken;
    end
  end

  // r_run holds the pipeline in its reset state until the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_run <= 1'b0;
    else        r_run <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= NUM_FWD; k++) r_rec[k] <= '0;
    end else if (!w_freeze) begin
      for (int k = NUM_FWD; k >= 2; k--) r_rec[k] <= r_rec[k-1];
      if (w_load_stall) begin
        r_rec[1] <= '0;
      end else begin
        r_rec[1].vld <= bus.id_valid & bus.id_wen & (bus.id_waddr != '0);
        r_rec[1].wa  <= bus.id_waddr;
        r_rec[1].ld  <= bus.id_is_load;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_cnt <= '0;
      r_mem_cnt  <= '0;
    end else if (w_cnt_ok) begin
      if (bus.mem_busy) begin
        if (r_mem_cnt != '1) r_mem_cnt <= r_mem_cnt + 1'b1;
      end else if (w_load_stall) begin
        if (r_load_cnt != '1) r_load_cnt <= r_load_cnt + 1'b1;
      end
    end
  end

  assign bus.load_stall_cnt = r_load_cnt;
  assign bus.mem_stall_cnt  = r_mem_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed self-checking bench for pipe_hazard_ctrl.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

  localparam int REG_AW = 5;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  pipe_hazard_ctrl_if #(.REG_AW(REG_AW), .SEL_W(SEL_W), .CNT_W(CNT_W)) bus ();

`ifdef HAZARD_DEBUG_STEP_EN
  logic debug_en   = 1'b0;
  logic debug_step = 1'b0;
`endif

  pipe_hazard_ctrl #(
    .REG_AW(REG_AW), .NUM_FWD(3), .LOAD_READY_STAGE(2), .CNT_W(CNT_W), .SEL_W(SEL_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef HAZARD_DEBUG_STEP_EN
    .debug_en   (debug_en),
    .debug_step (debug_step),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [4:0] w_en;
  assign w_en = {bus.if_en, bus.id_en, bus.exe_en, bus.mem_en, bus.wb_en};

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic ru, input logic tu, input logic st, input logic ld,
                       input logic we, input logic [4:0] wa, input logic br);
    bus.id_valid = v;   bus.id_rs = rs;       bus.id_rt = rt;
    bus.id_rs_used = ru; bus.id_rt_used = tu; bus.id_is_store = st;
    bus.id_is_load = ld; bus.id_wen = we;     bus.id_waddr = wa;
    bus.id_branch_taken = br;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    bus.mem_busy = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) tick();
    checks++; if (w_en !== 5'b00000) begin failures++; $display("FAIL rst_en got %b exp 00000", w_en); end
    checks++; if ({bus.id_flush, bus.exe_flush} !== 2'b11) begin failures++; $display("FAIL rst_flush got %b exp 11", {bus.id_flush, bus.exe_flush}); end
    checks++; if ({bus.fwd_a_sel, bus.fwd_b_sel, bus.fwd_store} !== 5'd0) begin failures++; $display("FAIL rst_fwd got %b exp 0", {bus.fwd_a_sel, bus.fwd_b_sel, bus.fwd_store}); end
    checks++; if ({bus.load_stall_cnt, bus.mem_stall_cnt} !== 8'd0) begin failures++; $display("FAIL rst_cnt got %h exp 00", {bus.load_stall_cnt, bus.mem_stall_cnt}); end
    #2 rst_n = 1'b1;
    #1;
    checks++; if (w_en !== 5'b00000 || bus.exe_flush !== 1'b1) begin failures++; $display("FAIL rst_release_early got en=%b xf=%b exp en=00000 xf=1", w_en, bus.exe_flush); end
    tick();
    checks++; if (w_en !== 5'b11111 || bus.id_flush !== 1'b0 || bus.exe_flush !== 1'b0) begin failures++; $display("FAIL rst_release got en=%b if=%b xf=%b exp 11111 0 0", w_en, bus.id_flush, bus.exe_flush); end
  endtask

  task automatic test_forward();
    drive(1, 0, 0, 0, 0, 0, 0, 1, 3, 0);
    tick();
    drive(1, 3, 0, 1, 0, 0, 0, 1, 7, 0);
    checks++; if (bus.fwd_a_sel !== 2'd1 || w_en !== 5'b11111) begin failures++; $display("FAIL fwd_exe got sel=%0d en=%b exp 1 11111", bus.fwd_a_sel, w_en); end
    tick();
    drive(1, 3, 7, 1, 1, 0, 0, 0, 0, 0);
    checks++; if (bus.fwd_a_sel !== 2'd2 || bus.fwd_b_sel !== 2'd1) begin failures++; $display("FAIL fwd_mem got a=%0d b=%0d exp 2 1", bus.fwd_a_sel, bus.fwd_b_sel); end
    tick();
    drive(1, 3, 0, 1, 1, 0, 0, 0, 0, 0);
    checks++; if (bus.fwd_a_sel !== 2'd3 || bus.fwd_b_sel !== 2'd0) begin failures++; $display("FAIL fwd_wb got a=%0d b=%0d exp 3 0", bus.fwd_a_sel, bus.fwd_b_sel); end
    drive(1, 3, 0, 0, 1, 0, 0, 0, 0, 0);
    checks++; if (bus.fwd_a_sel !== 2'd0) begin failures++; $display("FAIL fwd_unused got %0d exp 0", bus.fwd_a_sel); end
    idle(3);
  endtask

  task automatic test_load_use();
    logic [CNT_W-1:0] l0;
    drive(1, 0, 0, 0, 0, 0, 1, 1, 5, 0);
    tick();
    l0 = bus.load_stall_cnt;
    drive(1, 5, 0, 1, 0, 0, 0, 1, 6, 0);
    checks++; if (w_en !== 5'b00111 || bus.exe_flush !== 1'b1) begin failures++; $display("FAIL lu_stall got en=%b xf=%b exp 00111 1", w_en, bus.exe_flush); end
    tick();
    checks++; if (w_en !== 5'b11111 || bus.exe_flush !== 1'b0 || bus.fwd_a_sel !== 2'd2) begin failures++; $display("FAIL lu_resolve got en=%b xf=%b sel=%0d exp 11111 0 2", w_en, bus.exe_flush, bus.fwd_a_sel); end
    checks++; if (bus.load_stall_cnt !== l0 + 1'b1) begin failures++; $display("FAIL lu_cnt got %0d exp %0d", bus.load_stall_cnt, l0 + 1'b1); end
    idle(3);
  endtask

  task automatic test_store();
    drive(1, 0, 0, 0, 0, 0, 1, 1, 5, 0);
    tick();
    drive(1, 2, 5, 1, 1, 1, 0, 0, 0, 0);
    checks++; if (w_en !== 5'b11111 || bus.fwd_store !== 1'b1 || bus.fwd_b_sel !== 2'd0 || bus.fwd_a_sel !== 2'd0) begin failures++; $display("FAIL st_bypass got en=%b fs=%b b=%0d a=%0d exp 11111 1 0 0", w_en, bus.fwd_store, bus.fwd_b_sel, bus.fwd_a_sel); end
    drive(1, 2, 5, 1, 1, 0, 0, 1, 9, 0);
    checks++; if (w_en !== 5'b00111 || bus.fwd_store !== 1'b0) begin failures++; $display("FAIL st_nonstore got en=%b fs=%b exp 00111 0", w_en, bus.fwd_store); end
    drive(1, 5, 5, 1, 1, 1, 0, 0, 0, 0);
    checks++; if (w_en !== 5'b00111 || bus.fwd_store !== 1'b0) begin failures++; $display("FAIL st_rs_block got en=%b fs=%b exp 00111 0", w_en, bus.fwd_store); end
    idle(3);
  endtask

  task automatic test_mem_busy();
    logic [CNT_W-1:0] l0, m0;
    drive(1, 0, 0, 0, 0, 0, 1, 1, 5, 0);
    tick();
    l0 = bus.load_stall_cnt;
    m0 = bus.mem_stall_cnt;
    bus.mem_busy = 1'b1;
    drive(1, 5, 0, 1, 0, 0, 0, 1, 6, 0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (w_en !== 5'b00000 || bus.exe_flush !== 1'b0 || bus.id_flush !== 1'b0) begin failures++; $display("FAIL mb_freeze%0d got en=%b xf=%b if=%b exp 00000 0 0", i, w_en, bus.exe_flush, bus.id_flush); end
      tick();
    end
    bus.mem_busy = 1'b0;
    #1;
    checks++; if (bus.mem_stall_cnt !== m0 + 4'd4 || bus.load_stall_cnt !== l0) begin failures++; $display("FAIL mb_cnt got m=%0d l=%0d exp %0d %0d", bus.mem_stall_cnt, bus.load_stall_cnt, m0 + 4'd4, l0); end
    checks++; if (w_en !== 5'b00111 || bus.exe_flush !== 1'b1) begin failures++; $display("FAIL mb_then_stall got en=%b xf=%b exp 00111 1", w_en, bus.exe_flush); end
    tick();
    checks++; if (w_en !== 5'b11111 || bus.fwd_a_sel !== 2'd2 || bus.load_stall_cnt !== l0 + 1'b1) begin failures++; $display("FAIL mb_resolve got en=%b sel=%0d l=%0d exp 11111 2 %0d", w_en, bus.fwd_a_sel, bus.load_stall_cnt, l0 + 1'b1); end
    idle(3);
  endtask

  task automatic test_branch();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    checks++; if (bus.id_flush !== 1'b1 || w_en !== 5'b11111 || bus.exe_flush !== 1'b0) begin failures++; $display("FAIL br_flush got if=%b en=%b xf=%b exp 1 11111 0", bus.id_flush, w_en, bus.exe_flush); end
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (bus.id_flush !== 1'b0) begin failures++; $display("FAIL br_one_cycle got %b exp 0", bus.id_flush); end
    drive(1, 0, 0, 0, 0, 0, 1, 1, 5, 0);
    tick();
    drive(1, 5, 0, 1, 0, 0, 0, 0, 0, 1);
    checks++; if (bus.id_flush !== 1'b0 || bus.exe_flush !== 1'b1) begin failures++; $display("FAIL br_in_stall got if=%b xf=%b exp 0 1", bus.id_flush, bus.exe_flush); end
    tick();
    checks++; if (bus.id_flush !== 1'b1 || bus.exe_flush !== 1'b0) begin failures++; $display("FAIL br_after_stall got if=%b xf=%b exp 1 0", bus.id_flush, bus.exe_flush); end
    idle(3);
  endtask

  task automatic test_async_reset();
    drive(1, 0, 0, 0, 0, 0, 1, 1, 5, 0);
    tick();
    drive(1, 5, 0, 1, 0, 0, 0, 1, 6, 0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (w_en !== 5'b00000 || {bus.id_flush, bus.exe_flush} !== 2'b11 || bus.fwd_a_sel !== 2'd0) begin failures++; $display("FAIL ar_outputs got en=%b fl=%b sel=%0d exp 00000 11 0", w_en, {bus.id_flush, bus.exe_flush}, bus.fwd_a_sel); end
    checks++; if ({bus.load_stall_cnt, bus.mem_stall_cnt} !== 8'd0) begin failures++; $display("FAIL ar_cnt got %h exp 00", {bus.load_stall_cnt, bus.mem_stall_cnt}); end
    #2 rst_n = 1'b1;
    tick();
    checks++; if (w_en !== 5'b11111 || bus.fwd_a_sel !== 2'd0 || bus.exe_flush !== 1'b0) begin failures++; $display("FAIL ar_abandon got en=%b sel=%0d xf=%b exp 11111 0 0", w_en, bus.fwd_a_sel, bus.exe_flush); end
    idle(3);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 17; i++) begin
      drive(1, 0, 0, 0, 0, 0, 1, 1, 5, 0);
      tick();
      drive(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
      if (i == 16) begin
        checks++; if (w_en !== 5'b00111) begin failures++; $display("FAIL sat_stall got en=%b exp 00111", w_en); end
      end
      tick();
      if (i == 14) begin
        checks++; if (bus.load_stall_cnt !== 4'hF) begin failures++; $display("FAIL sat_reach got %0d exp 15", bus.load_stall_cnt); end
      end
    end
    checks++; if (bus.load_stall_cnt !== 4'hF) begin failures++; $display("FAIL sat_hold got %0d exp 15", bus.load_stall_cnt); end
    idle(2);
  endtask

  initial begin
    bus.mem_busy = 1'b0;
    test_reset();
    test_forward();
    test_load_use();
    test_store();
    test_mem_busy();
    test_branch();
    test_async_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
